// File: rtl/x_oneshot_pkg.sv
// Shared definitions for the x_oneshot family: per-channel state encoding.
package x_oneshot_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/x_oneshot_ch.sv
// One one-shot channel: state machine, shared pulse/holdoff counter and registered q.
module x_oneshot_ch
    import x_oneshot_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            d,
    input  logic [CNTW-1:0] width,
    input  logic [CNTW-1:0] holdoff,
    input  logic            retrig,
    output logic            q,
    output logic            busy
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t          state;
    state_t          state_next;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_next;

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            q     <= (state == PULSE);
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (d) begin
                    state_next = PULSE;
                    cnt_next   = (width == '0) ? '0 : width - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end else if (holdoff != '0) begin
                    state_next = HOLDOFF;
                    cnt_next   = holdoff - CNT_ONE;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLDOFF: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!d || retrig) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: rtl/x_oneshot_nch.sv
// NCH-channel one-shot; define X_ONESHOT_NCH_SYNC_EN to add a 2-stage synchroniser on d.
module x_oneshot_nch #(
    parameter int NCH  = 8,
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NCH-1:0]  d,
    input  logic [CNTW-1:0] width,
    input  logic [CNTW-1:0] holdoff,
    input  logic            retrig,
    output logic [NCH-1:0]  q,
    output logic [NCH-1:0]  busy
);

    logic [NCH-1:0] d_fsm;

`ifdef X_ONESHOT_NCH_SYNC_EN
    logic [NCH-1:0] sync_s1;
    logic [NCH-1:0] sync_s2;

    // Synchroniser is cleared by reset so a stale high level cannot retrigger after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= d;
            sync_s2 <= sync_s1;
        end
    end

    assign d_fsm = sync_s2;
`else
    assign d_fsm = d;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        x_oneshot_ch #(
            .CNTW (CNTW)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .d       (d_fsm[i]),
            .width   (width),
            .holdoff (holdoff),
            .retrig  (retrig),
            .q       (q[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: doc/x_oneshot_nch.md
Name: x_oneshot_nch

Overview:
- Parametrised multi-channel digital one-shot; next generation of the single-bit one-shot used for trigger, strobe and command-edge pulses.
- NCH independent channels. Each produces a registered pulse of run-time programmable width on a rising level of its input.
- Each channel has an optional holdoff dead-time, then either waits for its input to drop (legacy) or re-arms immediately (retrigger mode).
- Sits between synchronous level sources (VME register bits, trigger flags) and logic needing clean, bounded-width strobes.

Parameters:
- NCH, 8, number of independent channels (1..32).
- CNTW, 8, width of pulse-width and holdoff counters. Maximum pulse = 2^CNTW-1 clocks.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- d  input  NCH  per-channel trigger levels, synchronous to clock unless X_ONESHOT_NCH_SYNC_EN is defined.
- width  input  CNTW  pulse width in clocks, shared by all channels; 0 is treated as 1.
- holdoff  input  CNTW  dead-time in clocks after the pulse ends, before hold/re-arm; 0 means no holdoff.
- retrig  input  1  0 = re-arm only after d goes low; 1 = re-arm without waiting for d low.
- q  output  NCH  registered one-shot pulses.
- busy  output  NCH  channel state is not idle; combinational decode of the state register.

Behaviour:
- Reset, asserted asynchronously: every channel state = idle, counter = 0, q = 0, busy = 0. Reset asserted mid-pulse drops q immediately, with no partial completion. After reset deasserts, a channel whose d is already high triggers on the first clock.
- Per-channel states: idle, pulse, holdoff, hold. Encoding is a 2-bit register. Any illegal value returns to idle on the next clock.
- idle: if d=1, go to pulse and load cnt = max(width,1)-1.
- pulse: if cnt != 0, decrement. If cnt == 0 and holdoff != 0, go to holdoff and load cnt = holdoff-1. If cnt == 0 and holdoff == 0, go to hold.
- holdoff: decrement cnt; at cnt == 0 go to hold. d is ignored here.
- hold: if d=0 or retrig=1, go to idle; otherwise stay.
- q[i] <= (state[i]==pulse), registered.
- Latency: d sampled high at edge k means state=pulse after edge k, and q high after edge k+1. q stays high for exactly max(width,1) clocks.
- width and holdoff are sampled only at the load points. Changes mid-count do not affect the count in progress.
- retrig=1 with d held high gives a periodic pulse train of period max(width,1)+holdoff+2 clocks. The +2 covers the hold and idle cycles.
- A d pulse shorter than one clock that is sampled high still yields a full-width q. d dropping during pulse or holdoff does not shorten either phase.
- Channels are fully independent; simultaneous triggers on all channels are legal.
- busy[i] = (state[i] != idle).

Optional Feature:
- Macro X_ONESHOT_NCH_SYNC_EN.
- Defined: each d bit passes through a 2-stage synchroniser (flops cleared by reset) before the state machine. d-to-q latency rises by 2 clocks to edge k+3. Inputs may be asynchronous.
- Undefined: d feeds the state machine directly, with edge k+1 latency as above. No extra flops are inferred.

Decomposition:
- Shared package x_oneshot_pkg holds:
  - state constants IDLE=0, PULSE=1, HOLDOFF=2, HOLD=3;
  - the state register width constant (2).
- One sub-module, x_oneshot_ch:
  - contains a single channel's state machine, counter and output flop;
  - the top generates NCH instances and shares width, holdoff and retrig;
  - the synchroniser stays in the top under the macro.

Test Plan:
- Reset then d[0] 0->1 held 20 clocks, width=3, holdoff=0, retrig=0 -> q[0] high exactly 3 clocks starting 2 edges after d rises. No second pulse until d drops; busy[0] stays 1 until d=0 plus 1 clock.
- width=0, single-cycle d[1] pulse -> q[1] high exactly 1 clock. All other q bits stay 0.
- width=2, holdoff=4, retrig=1, d[2] held high 40 clocks -> q[2] pulses 2 clocks high with period 8.
- d=all ones in one clock, width=5 -> all NCH q bits rise together and fall together after 5 clocks.
- reset asserted 2 clocks into a width=10 pulse -> q drops asynchronously and busy=0. After release with d still high, a full 10-clock pulse follows.
- width changed 4->9 mid-pulse -> current pulse stays 4 clocks; the next trigger gives 9. With X_ONESHOT_NCH_SYNC_EN, the same stimulus shows the rise delayed by 2 extra clocks.
